// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus: default widths, region map and
// the copy-master state encoding.
package bus_pkg;

   localparam int unsigned BUS_ADDR_W = 16;
   localparam int unsigned BUS_DATA_W = 32;

   // Region is selected by the top address nibble.
   localparam logic [3:0] REGION_RAM = 4'h0;
   localparam logic [3:0] REGION_LED = 4'h1;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StWr,
      StFin
   } copy_state_e;

endpackage

// File: rtl/bus_copy_master.sv
// Word copier acting as a second bus master: one read then one write per word,
// with a read-response timeout that aborts the copy and flags a sticky error.
module bus_copy_master
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = BUS_ADDR_W,
   parameter int unsigned DATA_W  = BUS_DATA_W,
   parameter int unsigned LEN_W   = 12,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  count,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] Stride = ADDR_W'(WORD_BYTES);

   copy_state_e state_q, state_d;

   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         count_q   <= '0;
         tmo_q     <= '0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         count_q   <= count_d;
         tmo_q     <= tmo_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      count_d   = count_q;
      tmo_d     = tmo_q;
      error_d   = error_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               src_d   = src_addr & AlignMask;
               dst_d   = dst_addr & AlignMask;
               len_d   = len;
               count_d = '0;
               error_d = 1'b0;
               state_d = (len == '0) ? StFin : StRdReq;
            end
         end
         StRdReq: begin
            tmo_d   = TmoW'(1);
            state_d = StRdWait;
         end
         StRdWait: begin
            if (rd_valid) begin
               wr_data_d = rd_data;
               state_d   = StWr;
            end else if (32'(tmo_q) + 32'd1 >= TIMEOUT) begin
               error_d = 1'b1;
               state_d = StFin;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StWr: begin
            count_d = count_q + LEN_W'(1);
            state_d = (count_q + LEN_W'(1) == len_q) ? StFin : StRdReq;
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Strobes are registered against the state being entered so they line up
      // with RD_REQ/WR; done and the busy drop trail FIN by one cycle.
      rd_en_d = (state_d == StRdReq);
      wr_en_d = (state_d == StWr);
      busy_d  = (state_d != StIdle);
      done_d  = (state_q == StFin);

      if (rd_en_d) begin
         rd_addr_d = src_d + ADDR_W'(count_d) * Stride;
      end
      if (wr_en_d) begin
         wr_addr_d = dst_q + ADDR_W'(count_q) * Stride;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;
   assign count   = count_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: ram/led/rom responders behind a region decode and a
// transaction-level copy model that predicts bus traffic, flags and done timing.
module tb_bus_copy_master;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LEN_W   = 12;
   localparam int unsigned TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] src_addr, dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy, done, error;
   logic [LEN_W-1:0]  count;
   logic              rd_en, wr_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [DATA_W-1:0] rd_data = '0;
   logic              rd_valid = 1'b0;
   logic [DATA_W-1:0] wr_data;

   // Backdoor preload port into the responders
   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [DATA_W-1:0] bd_data = '0;

   logic [DATA_W-1:0] ram [1024];
   logic [DATA_W-1:0] led_reg;
   logic [DATA_W-1:0] ram_ref [1024];
   logic [DATA_W-1:0] led_ref;

   int n_cmp = 0;
   int n_bad = 0;

   logic [ADDR_W-1:0] exp_rd_a[$], got_rd_a[$];
   int                exp_rd_k[$], got_rd_k[$];
   logic [ADDR_W-1:0] exp_wr_a[$], got_wr_a[$];
   logic [DATA_W-1:0] exp_wr_d[$], got_wr_d[$];
   int                exp_wr_k[$], got_wr_k[$];
   logic              exp_err;
   int                exp_cnt;
   int                exp_done_k;

   always #5 clk = ~clk;

   bus_copy_master #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .count    (count),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return {16'hB007, a};
   endfunction

   // Responders: region 0 ram, region 1 led register, region F read-only rom
   always @(posedge clk) begin
      rd_valid <= 1'b0;
      if (rd_en) begin
         case (rd_addr[15:12])
            4'h0: begin rd_valid <= 1'b1; rd_data <= ram[rd_addr[11:2]]; end
            4'h1: begin rd_valid <= 1'b1; rd_data <= led_reg; end
            4'hF: begin rd_valid <= 1'b1; rd_data <= rom_word(rd_addr); end
            default: ;
         endcase
      end
      if (wr_en) begin
         case (wr_addr[15:12])
            4'h0: ram[wr_addr[11:2]] <= wr_data;
            4'h1: led_reg <= wr_data;
            default: ;
         endcase
      end
      if (bd_we) begin
         if (bd_addr[15:12] == 4'h1) led_reg <= bd_data;
         else ram[bd_addr[11:2]] <= bd_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      if (a[15:12] == 4'h1) led_ref = d;
      else ram_ref[a[11:2]] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic ref_read(input logic [ADDR_W-1:0] a, output bit ok, output logic [DATA_W-1:0] v);
      ok = 1'b1;
      case (a[15:12])
         4'h0:    v = ram_ref[a[11:2]];
         4'h1:    v = led_ref;
         4'hF:    v = rom_word(a);
         default: begin ok = 1'b0; v = '0; end
      endcase
   endtask

   // Expected traffic, in edges after the start edge: word i reads at 3i, writes at 3i+2;
   // a read with no responder times out with done TIMEOUT+1 edges after it.
   task automatic model_copy(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                             input int n);
      logic [ADDR_W-1:0] s, d, a, w;
      logic [DATA_W-1:0] v;
      bit ok;
      exp_rd_a.delete(); exp_rd_k.delete();
      exp_wr_a.delete(); exp_wr_d.delete(); exp_wr_k.delete();
      s = src & 16'hFFFC;
      d = dst & 16'hFFFC;
      exp_err = 1'b0;
      exp_cnt = 0;
      exp_done_k = 3 * n + 1;
      for (int i = 0; i < n; i++) begin
         a = s + 16'(4 * i);
         exp_rd_a.push_back(a);
         exp_rd_k.push_back(3 * i);
         ref_read(a, ok, v);
         if (!ok) begin
            exp_err = 1'b1;
            exp_done_k = 3 * i + int'(TIMEOUT) + 1;
            break;
         end
         w = d + 16'(4 * i);
         exp_wr_a.push_back(w);
         exp_wr_d.push_back(v);
         exp_wr_k.push_back(3 * i + 2);
         if (w[15:12] == 4'h0) ram_ref[w[11:2]] = v;
         else if (w[15:12] == 4'h1) led_ref = v;
         exp_cnt = i + 1;
      end
   endtask

   // Called at a negedge with the DUT idle. poke_k >= 0 re-pulses start while busy.
   task automatic run_copy(input string tag, input logic [ADDR_W-1:0] src,
                           input logic [ADDR_W-1:0] dst, input int n, input int poke_k);
      int done_k = -1;
      int both = 0;
      int busy_bad = 0;
      int limit;
      model_copy(src, dst, n);
      limit = exp_done_k + 5;
      got_rd_a.delete(); got_rd_k.delete();
      got_wr_a.delete(); got_wr_d.delete(); got_wr_k.delete();
      src_addr = src; dst_addr = dst; len = LEN_W'(n); start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= limit; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (rd_en && wr_en) both++;
         if (rd_en) begin got_rd_a.push_back(rd_addr); got_rd_k.push_back(k); end
         if (wr_en) begin
            got_wr_a.push_back(wr_addr); got_wr_d.push_back(wr_data); got_wr_k.push_back(k);
         end
         if (done) begin done_k = k; break; end
         if (busy !== 1'b1) busy_bad++;
         if (k == poke_k) begin
            start = 1'b1; src_addr = 16'h2000; dst_addr = 16'h0FF0; len = LEN_W'(1);
         end
         if (k == poke_k + 1) start = 1'b0;
         @(posedge clk);
      end
      start = 1'b0;
      check({tag, "_done_k"}, 64'(done_k), 64'(exp_done_k));
      check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
      check({tag, "_busy_fin"}, 64'(busy), 64'd0);
      check({tag, "_error"}, 64'(error), 64'(exp_err));
      check({tag, "_count"}, 64'(count), 64'(exp_cnt));
      check({tag, "_rd_wr_excl"}, 64'(both), 64'd0);
      check({tag, "_n_rd"}, 64'(got_rd_a.size()), 64'(exp_rd_a.size()));
      for (int i = 0; i < got_rd_a.size() && i < exp_rd_a.size(); i++)
         check({tag, "_rd"}, {16'(got_rd_k[i]), got_rd_a[i]}, {16'(exp_rd_k[i]), exp_rd_a[i]});
      check({tag, "_n_wr"}, 64'(got_wr_a.size()), 64'(exp_wr_a.size()));
      for (int i = 0; i < got_wr_a.size() && i < exp_wr_a.size(); i++)
         check({tag, "_wr"}, {got_wr_k[i][7:0], 8'h0, got_wr_a[i], got_wr_d[i]},
               {exp_wr_k[i][7:0], 8'h0, exp_wr_a[i], exp_wr_d[i]});
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_error_hold"}, 64'(error), 64'(exp_err));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
      check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
   endtask

   initial begin
      int quiet;
      int diffs;
      logic [ADDR_W-1:0] s, d;
      int n, pk;

      rst_n = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      #1 rst_n = 1'b0;
      #1 check_all_zero("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 1024; i++) bd_write(16'(i * 4), $urandom);
      bd_write(16'h0000, 32'h11);
      bd_write(16'h0004, 32'h22);
      bd_write(16'h0008, 32'h33);
      bd_write(16'h000C, 32'h44);
      bd_write(16'h1000, 32'h0001_0000);

      run_copy("t1", 16'h0000, 16'h0100, 4, -1);
      check("t1_ram0", 64'(ram[16'h0100 >> 2]), 64'h11);
      check("t1_ram3", 64'(ram[16'h010C >> 2]), 64'h44);
      check("t1_done13", 64'(exp_done_k), 64'd13);

      run_copy("t2_unmapped", 16'h2000, 16'h0300, 2, -1);
      run_copy("t3_len0", 16'h0010, 16'h0310, 0, -1);
      run_copy("t4_led", 16'h1000, 16'h0200, 1, -1);
      check("t4_ram", 64'(ram[16'h0200 >> 2]), 64'h0001_0000);
      run_copy("t5_wrap", 16'hFFFC, 16'h0400, 2, -1);
      run_copy("t6_poke", 16'h0021, 16'h0502, 3, 2);

      // Reset mid-RD_WAIT: everything clears at once and the copy never finishes
      src_addr = 16'h0044; dst_addr = 16'h0700; len = LEN_W'(2); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_mid");
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || rd_en || wr_en || busy) quiet++;
      end
      check("rst_quiet", 64'(quiet), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_copy("t6_after_rst", 16'h0080, 16'h0600, 3, -1);

      for (int it = 0; it < 14; it++) begin
         s = 16'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3));
         d = 16'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3));
         if (it % 4 == 3) s = 16'h1000 | 16'($urandom_range(0, 3) * 4);
         if (it % 5 == 4) s = 16'hFFF0;
         if (it % 6 == 5) s = 16'h3000 | 16'($urandom_range(0, 255) * 4);
         n = $urandom_range(0, 8);
         pk = (n >= 2 && (it % 2 == 0)) ? $urandom_range(0, 3 * n - 1) : -1;
         run_copy("rnd", s, d, n, pk);
      end

      diffs = 0;
      for (int i = 0; i < 1024; i++) if (ram[i] !== ram_ref[i]) diffs++;
      check("ram_final", 64'(diffs), 64'd0);
      check("led_final", 64'(led_reg), 64'(led_ref));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
